// File: rtl/ram_pkg.sv
// Shared constants and helpers for the masked-write RAM with clear sequencer.
package ram_pkg;

  // Read-under-write behaviour of a registered read port
  localparam int unsigned RUW_READ_FIRST  = 0;
  localparam int unsigned RUW_WRITE_FIRST = 1;
  localparam int unsigned RUW_DONT_CARE   = 2;

  // Widest word the merge helper handles; callers cast in and out
  localparam int unsigned MERGE_MAX_W = 1024;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Ceiling log2 for elaboration-time sizing
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Replace the bits of old_word selected by bit_mask with new_word
  function automatic logic [MERGE_MAX_W-1:0] mask_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_W-1:0] bit_mask
  );
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/ram_sync_read_port.sv
// One registered read port with optional write-first bypass merge.
module ram_sync_read_port
  import ram_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_en,
  input  logic [WORD_WIDTH-1:0] mem_word,
  input  logic                  wr_hit,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [WORD_WIDTH-1:0] wr_bmask,
  output logic [WORD_WIDTH-1:0] rd_data
);

  logic [WORD_WIDTH-1:0] rd_data_q;
  logic [WORD_WIDTH-1:0] rd_data_d;

  // Capture on rd_en, folding in a same-cycle write when bypass is requested
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_word;
      if (wr_hit) begin
        rd_data_d = WORD_WIDTH'(mask_merge(MERGE_MAX_W'(mem_word),
                                           MERGE_MAX_W'(wr_data),
                                           MERGE_MAX_W'(wr_bmask)));
      end
    end
  end

  // Read data register, cleared by reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_1w_nr_masked_clear.sv
// Inferred RAM: one lane-masked write port, N read ports, post-reset clear sequencer.
module ram_1w_nr_masked_clear
  import ram_pkg::*;
#(
  parameter int unsigned           WORD_COUNT       = 64,
  parameter int unsigned           WORD_WIDTH       = 32,
  parameter int unsigned           MASK_WIDTH       = 4,
  parameter int unsigned           READ_PORTS       = 2,
  parameter bit                    READ_SYNC        = 1'b1,
  parameter string                 READ_UNDER_WRITE = "readFirst",
  parameter bit                    CLEAR_ON_RESET   = 1'b1,
  parameter logic [WORD_WIDTH-1:0] CLEAR_VALUE      = '0,
  localparam int unsigned          AW = (clog2(WORD_COUNT) > 1) ? clog2(WORD_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             wr_en,
  input  logic [MASK_WIDTH-1:0]            wr_mask,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [WORD_WIDTH-1:0]            wr_data,
  output logic                             wr_ready,
  input  logic [READ_PORTS-1:0]            rd_en,
  input  logic [READ_PORTS*AW-1:0]         rd_addr,
  output logic [READ_PORTS*WORD_WIDTH-1:0] rd_data,
  output logic                             clear_busy
);

  localparam int unsigned LANE = WORD_WIDTH / MASK_WIDTH;
  localparam int unsigned RUW_MODE =
    (READ_UNDER_WRITE == "writeFirst") ? RUW_WRITE_FIRST :
    ((READ_UNDER_WRITE == "dontCare") ? RUW_DONT_CARE : RUW_READ_FIRST);
  localparam bit RD_BYPASS = (RUW_MODE == RUW_WRITE_FIRST);
  localparam bit ADDR_FULL = (longint'(WORD_COUNT) == (64'd1 << AW));

  clr_state_e    state_q;
  clr_state_e    state_d;
  logic [AW-1:0] clear_cnt_q;
  logic [AW-1:0] clear_cnt_d;

  logic                  wr_in_range;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_lmask;
  logic [WORD_WIDTH-1:0] mem_bmask;

  (* ram_style = "distributed" *)
  logic [WORD_WIDTH-1:0] mem [0:WORD_COUNT-1];

  // Clear sequencer next state: walk every address once, then stay READY
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    if (state_q == ST_CLEAR) begin
      clear_cnt_d = clear_cnt_q + AW'(1);
      if (clear_cnt_q == AW'(WORD_COUNT - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  // Sequencer state register; reset restarts the clear from address 0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  assign wr_ready   = (state_q == ST_READY);
  assign clear_busy = (state_q == ST_CLEAR);

  // Out-of-range write addresses are only possible for non power-of-two depths
  if (ADDR_FULL) begin : g_wr_full
    assign wr_in_range = 1'b1;
  end else begin : g_wr_part
    assign wr_in_range = (wr_addr < AW'(WORD_COUNT));
  end

  // Write mux: the clear path owns the port while the sequencer runs
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_addr;
    mem_wdata = wr_data;
    mem_lmask = wr_mask;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clear_cnt_q;
      mem_wdata = CLEAR_VALUE;
      mem_lmask = '1;
    end else begin
      mem_we = wr_en & wr_in_range;
    end
  end

  // Lane enables expanded to a per-bit mask for the bypass merge
  always_comb begin
    mem_bmask = '0;
    for (int l = 0; l < MASK_WIDTH; l++) begin
      mem_bmask[l*LANE +: LANE] = {LANE{mem_lmask[l]}};
    end
  end

  // Storage: lane-granular write, no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < MASK_WIDTH; l++) begin
        if (mem_lmask[l]) begin
          mem[mem_addr][l*LANE +: LANE] <= mem_wdata[l*LANE +: LANE];
        end
      end
    end
  end

  // Per-port address decode and either a registered or a combinational read
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0]         addr_p;
    logic                  in_range_p;
    logic [WORD_WIDTH-1:0] word_p;
    logic                  hit_p;

    assign addr_p = rd_addr[p*AW +: AW];

    if (ADDR_FULL) begin : g_full
      assign in_range_p = 1'b1;
    end else begin : g_part
      assign in_range_p = (addr_p < AW'(WORD_COUNT));
    end

    assign word_p = in_range_p ? mem[addr_p] : '0;
    assign hit_p  = RD_BYPASS && mem_we && (mem_addr == addr_p);

    if (READ_SYNC) begin : g_sync
      ram_sync_read_port #(
        .WORD_WIDTH (WORD_WIDTH)
      ) u_port (
        .clk      (clk),
        .resetn   (resetn),
        .rd_en    (rd_en[p]),
        .mem_word (word_p),
        .wr_hit   (hit_p),
        .wr_data  (mem_wdata),
        .wr_bmask (mem_bmask),
        .rd_data  (rd_data[p*WORD_WIDTH +: WORD_WIDTH])
      );
    end else begin : g_async
      assign rd_data[p*WORD_WIDTH +: WORD_WIDTH] = word_p;
    end
  end

endmodule

// File: tb/tb_ram_1w_nr_masked_clear.sv
// Bench: two instances (64-deep readFirst, 48-deep writeFirst) on shared stimulus,
// compared every cycle against an array model plus literal spot checks.
module tb_ram_1w_nr_masked_clear;

  localparam int unsigned AW   = 6;
  localparam int unsigned WC_A = 64;
  localparam int unsigned WC_B = 48;
  localparam logic [31:0] CV   = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_en;
  logic [11:0] rd_addr;

  logic        a_wr_ready, b_wr_ready;
  logic        a_busy, b_busy;
  logic [63:0] a_rd_data, b_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_1w_nr_masked_clear #(
    .WORD_COUNT(WC_A), .WORD_WIDTH(32), .MASK_WIDTH(4), .READ_PORTS(2),
    .READ_SYNC(1'b1), .READ_UNDER_WRITE("readFirst"),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) dut_a (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(a_wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .clear_busy(a_busy)
  );

  ram_1w_nr_masked_clear #(
    .WORD_COUNT(WC_B), .WORD_WIDTH(32), .MASK_WIDTH(4), .READ_PORTS(2),
    .READ_SYNC(1'b1), .READ_UNDER_WRITE("writeFirst"),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) dut_b (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(b_wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .clear_busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm   [2][64];
  int          clr_left [2];
  logic [31:0] rexp [2][2];
  bit          rok  [2][2];
  bit          model_live = 1'b0;

  function automatic int wc(input int k);
    return (k == 0) ? int'(WC_A) : int'(WC_B);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  m);
    logic [31:0] r;
    r = old_w;
    for (int l = 0; l < 4; l++) if (m[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      model_live = 1'b1;
      for (int k = 0; k < 2; k++) begin
        clr_left[k] = wc(k);
        for (int p = 0; p < 2; p++) begin
          rexp[k][p] = 32'h0;
          rok[k][p]  = 1'b1;
        end
      end
    end else if (model_live) begin
      for (int k = 0; k < 2; k++) begin
        int wa;
        wa = int'(wr_addr);
        for (int p = 0; p < 2; p++) begin
          if (rd_en[p]) begin
            int ra;
            logic [31:0] w;
            ra = int'(rd_addr[p*AW +: AW]);
            if (clr_left[k] > 0) begin
              rok[k][p] = 1'b0;
            end else begin
              w = (ra < wc(k)) ? mm[k][ra] : 32'h0;
              if (k == 1 && wr_en && wa == ra && ra < wc(k)) w = lane_merge(w, wr_data, wr_mask);
              rexp[k][p] = w;
              rok[k][p]  = 1'b1;
            end
          end
        end
        if (clr_left[k] > 0) begin
          mm[k][wc(k) - clr_left[k]] = CV;
          clr_left[k] = clr_left[k] - 1;
        end else if (wr_en && wa < wc(k)) begin
          mm[k][wa] = lane_merge(mm[k][wa], wr_data, wr_mask);
        end
      end
    end
  end

  function automatic logic [31:0] dut_rd(input int k, input int p);
    return (k == 0) ? a_rd_data[p*32 +: 32] : b_rd_data[p*32 +: 32];
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 2; k++) begin
        logic busy, rdy;
        busy = (k == 0) ? a_busy : b_busy;
        rdy  = (k == 0) ? a_wr_ready : b_wr_ready;
        chk($sformatf("model_busy%0d", k), 32'(busy), 32'(clr_left[k] > 0));
        chk($sformatf("model_ready%0d", k), 32'(rdy), 32'(clr_left[k] == 0));
        for (int p = 0; p < 2; p++) begin
          if (rok[k][p]) chk($sformatf("model_rd%0d_p%0d", k, p), dut_rd(k, p), rexp[k][p]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    cyc(1);
    wr_en = 1'b0;
  endtask

  function automatic logic [5:0] pick_addr(input logic [5:0] wa);
    return ($urandom_range(0, 3) == 0) ? wa : 6'($urandom);
  endfunction

  initial begin
    int na, nb;
    resetn = 1'b0; wr_en = 1'b0; wr_mask = 4'h0; wr_addr = 6'd0; wr_data = 32'h0;
    rd_en = 2'b00; rd_addr = 12'h0;
    cyc(2);
    chk("rst_busy_a", 32'(a_busy), 32'd1);
    chk("rst_ready_a", 32'(a_wr_ready), 32'd0);
    chk("rst_busy_b", 32'(b_busy), 32'd1);
    chk("rst_rd_a", a_rd_data[31:0], 32'h0);
    chk("rst_rd_b", b_rd_data[63:32], 32'h0);

    // Clear with a write attempt that must be dropped; reset again mid-clear
    resetn = 1'b1; wr_en = 1'b1; wr_addr = 6'd2; wr_data = 32'h5; wr_mask = 4'hF;
    cyc(20);
    chk("midclear_busy_b", 32'(b_busy), 32'd1);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    na = 0; nb = 0;
    for (int i = 1; i <= 100 && (na == 0 || nb == 0); i++) begin
      cyc(1);
      if (i == 10) wr_en = 1'b0;
      if (!a_busy && na == 0) na = i;
      if (!b_busy && nb == 0) nb = i;
    end
    chk("clear_len_a", 32'(na), 32'd64);
    chk("clear_len_b", 32'(nb), 32'd48);

    // Full sweep: cleared words everywhere, out-of-range reads of B return 0
    rd_en = 2'b11;
    for (int a = 0; a < 64; a++) begin
      rd_addr = {6'(63 - a), 6'(a)};
      cyc(1);
      chk("sweep_a", a_rd_data[31:0], CV);
      chk("sweep_b", b_rd_data[31:0], (a < 48) ? CV : 32'h0);
    end
    rd_en = 2'b00;

    // Lane-masked write
    write(6'd5, 32'h11223344, 4'hF);
    write(6'd5, 32'hAABBCCDD, 4'b0101);
    rd_en = 2'b01; rd_addr = {6'd0, 6'd5};
    cyc(1);
    chk("mask_a", a_rd_data[31:0], 32'h11BB33DD);
    chk("mask_b", b_rd_data[31:0], 32'h11BB33DD);
    rd_en = 2'b00;

    // Same-cycle read and write of one address
    write(6'd7, 32'h0, 4'hF);
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'hFFFFFFFF; wr_mask = 4'b0011;
    rd_en = 2'b01; rd_addr = {6'd0, 6'd7};
    cyc(1);
    wr_en = 1'b0;
    chk("ruw_readfirst", a_rd_data[31:0], 32'h0);
    chk("ruw_writefirst", b_rd_data[31:0], 32'h0000FFFF);
    cyc(1);
    chk("ruw_after_a", a_rd_data[31:0], 32'h0000FFFF);
    chk("ruw_after_b", b_rd_data[31:0], 32'h0000FFFF);

    // Independent ports: a disabled port holds its previous value
    write(6'd3, 32'h33333333, 4'hF);
    write(6'd9, 32'h99999999, 4'hF);
    rd_en = 2'b11; rd_addr = {6'd3, 6'd3};
    cyc(1);
    chk("mp_both_p0", a_rd_data[31:0], 32'h33333333);
    chk("mp_both_p1", a_rd_data[63:32], 32'h33333333);
    rd_en = 2'b01; rd_addr = {6'd9, 6'd3};
    cyc(1);
    chk("mp_en01_p0", a_rd_data[31:0], 32'h33333333);
    chk("mp_en01_p1_hold", a_rd_data[63:32], 32'h33333333);
    rd_en = 2'b10; rd_addr = {6'd9, 6'd9};
    cyc(1);
    chk("mp_en10_p0_hold", b_rd_data[31:0], 32'h33333333);
    chk("mp_en10_p1", b_rd_data[63:32], 32'h99999999);

    // Write beyond B's depth is ignored there
    write(6'd50, 32'h12345678, 4'hF);
    rd_en = 2'b01; rd_addr = {6'd0, 6'd50};
    cyc(1);
    chk("oob_wr_a", a_rd_data[31:0], 32'h12345678);
    chk("oob_wr_b", b_rd_data[31:0], 32'h0);

    // Randomised traffic with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_mask = 4'($urandom);
      wr_addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
      wr_data = $urandom;
      rd_en   = 2'($urandom);
      rd_addr = {pick_addr(wr_addr), pick_addr(wr_addr)};
      resetn  = (c != 1500);
      cyc(1);
    end
    wr_en = 1'b0; rd_en = 2'b00; resetn = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
